// File: rtl/upload_pkg.sv
// upload_pkg: shared widths, FSM encoding and default timeout for the upload arbiter
package upload_pkg;
  localparam int BYTE_W = 8;
  localparam int SRCID_W = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/upload_arbiter_if.sv
// upload_arbiter_if: per-source upload buses plus merged command-processor bus
interface upload_arbiter_if
  import upload_pkg::*;
#(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0] src_upload_req;
  logic [BYTE_W*NUM_SRC-1:0] src_upload_data;
  logic [SRCID_W*NUM_SRC-1:0] src_upload_source;
  logic [NUM_SRC-1:0] src_upload_valid;
  logic [NUM_SRC-1:0] src_upload_ready;
  logic upload_req;
  logic [BYTE_W-1:0] upload_data;
  logic [SRCID_W-1:0] upload_source;
  logic upload_valid;
  logic upload_ready;
  logic [NUM_SRC-1:0] grant_onehot;
  logic timeout_err;
  modport master (
    input src_upload_req, src_upload_data, src_upload_source, src_upload_valid, upload_ready,
    output src_upload_ready, upload_req, upload_data, upload_source, upload_valid, grant_onehot, timeout_err
  );
  modport slave (
    output src_upload_req, src_upload_data, src_upload_source, src_upload_valid, upload_ready,
    input src_upload_ready, upload_req, upload_data, upload_source, upload_valid, grant_onehot, timeout_err
  );
endinterface

// File: rtl/upload_arbiter_picker.sv
// rr_picker: combinational round-robin winner search starting just after i_last
module rr_picker #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_win,
  output logic          o_any
);
  logic [IW-1:0] w_idx;
  // Scan farthest-first so the nearest requester after i_last overwrites the rest.
  always_comb begin
    o_win = i_last;
    w_idx = i_last;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(i_last) + k) % N);
      if (i_req[w_idx]) o_win = w_idx;
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/upload_arbiter.sv
// upload_arbiter: packet-granular round-robin merge of NUM_SRC upload streams.
// Define UPLOAD_ARB_TIMEOUT_EN to force release of grants that stall for TIMEOUT_CYCLES.
module upload_arbiter
  import upload_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clk,
  input logic rst_n,
  upload_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_SRC);
  state_t r_state, w_next;
  logic [IW-1:0] r_grant, r_last, w_win;
  logic [NUM_SRC-1:0] w_cand, w_onehot;
  logic w_any, w_gnt, w_release, w_to;
  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("upload_arbiter: parameter out of range");
  end
  rr_picker #(.N(NUM_SRC), .IW(IW)) u_pick (
    .i_req(w_cand), .i_last(r_last), .o_win(w_win), .o_any(w_any)
  );
  assign w_gnt = r_state == GRANT;
  assign w_onehot = NUM_SRC'(1) << r_grant;
  assign w_release = w_gnt & ~bus.src_upload_req[r_grant];
  always_comb begin
    bus.upload_req = w_gnt;
    bus.upload_valid = w_gnt & bus.src_upload_valid[r_grant];
    bus.upload_data = w_gnt ? BYTE_W'(bus.src_upload_data >> (BYTE_W * r_grant)) : '0;
    bus.upload_source = w_gnt ? SRCID_W'(bus.src_upload_source >> (SRCID_W * r_grant)) : '0;
    bus.src_upload_ready = (w_gnt & bus.upload_ready) ? w_onehot : '0;
    bus.grant_onehot = w_gnt ? w_onehot : '0;
    w_next = w_gnt ? ((w_release | w_to) ? IDLE : GRANT) : (w_any ? GRANT : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last <= IW'(NUM_SRC - 1);
    end else begin
      r_state <= w_next;
      if (!w_gnt && w_any) r_grant <= w_win;
      if (w_gnt && w_next == IDLE) r_last <= r_grant;
    end
  end
`ifdef UPLOAD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic [NUM_SRC-1:0] r_mask;
  logic r_to_err, w_xfer;
  assign w_xfer = bus.upload_valid & bus.upload_ready;
  assign w_to = w_gnt & ~w_xfer & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_cand = bus.src_upload_req & ~r_mask;
  assign bus.timeout_err = r_to_err;
  // A timed-out source stays masked until it lets go of its request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_mask <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_cnt <= (w_gnt && !w_xfer && !w_to) ? r_cnt + 1'b1 : '0;
      r_mask <= (r_mask | (w_to ? w_onehot : '0)) & bus.src_upload_req;
      r_to_err <= w_to;
    end
  end
`else
  assign w_to = 1'b0;
  assign w_cand = bus.src_upload_req;
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_upload_arbiter.sv
// tb_upload_arbiter: directed scenarios for upload_arbiter with hand-computed expectations
module tb_upload_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] got[$];
  upload_arbiter_if #(.NUM_SRC(2)) bus ();
  upload_arbiter #(.NUM_SRC(2), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.upload_valid && bus.upload_ready) got.push_back({bus.upload_source, bus.upload_data});
  // {upload_req, grant_onehot[1:0], upload_valid, src_upload_ready[1:0], timeout_err}
  function automatic logic [6:0] st();
    return {bus.upload_req, bus.grant_onehot, bus.upload_valid, bus.src_upload_ready, bus.timeout_err};
  endfunction
  function automatic logic [15:0] ds();
    return {bus.upload_source, bus.upload_data};
  endfunction
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic drv(input logic i, input logic r, input logic v, input logic [7:0] d);
    bus.src_upload_req[i] = r;
    bus.src_upload_valid[i] = v;
    if (i) bus.src_upload_data[15:8] = d;
    else bus.src_upload_data[7:0] = d;
  endtask
  task automatic idle_all();
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    drv(1'b1, 1'b0, 1'b0, 8'h00);
    bus.upload_ready = 1'b1;
    step();
    step();
    got.delete();
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    drv(1'b0, 1'b1, 1'b1, 8'h5A);
    bus.upload_ready = 1'b1;
    step();
    step();
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0) begin n_bad++; $display("FAIL reset_status: got %b want %b", st(), 7'b0_00_0_00_0); end
    n_cmp++; if (ds() !== 16'h0000) begin n_bad++; $display("FAIL reset_bus: got %h want %h", ds(), 16'h0000); end
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    drv(1'b0, 1'b1, 1'b1, 8'h11);
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0) begin n_bad++; $display("FAIL single_idle: got %b want %b", st(), 7'b0_00_0_00_0); end
    step();
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0) begin n_bad++; $display("FAIL single_grant: got %b want %b", st(), 7'b1_01_1_01_0); end
    n_cmp++; if (ds() !== 16'hA011) begin n_bad++; $display("FAIL single_data: got %h want %h", ds(), 16'hA011); end
    step();
    drv(1'b0, 1'b1, 1'b1, 8'h22);
    step();
    drv(1'b0, 1'b1, 1'b1, 8'h33);
    step();
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    n_cmp++; if (st() !== 7'b1_01_0_01_0) begin n_bad++; $display("FAIL single_drop: got %b want %b", st(), 7'b1_01_0_01_0); end
    step();
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0 || ds() !== 16'h0000) begin n_bad++; $display("FAIL single_release: got %b/%h want %b/%h", st(), ds(), 7'b0, 16'h0); end
    n_cmp++; if (got.size() != 3 || got[0] !== 16'hA011 || got[1] !== 16'hA022 || got[2] !== 16'hA033) begin n_bad++; $display("FAIL single_bytes: got n=%0d %h %h %h want n=3 a011 a022 a033", got.size(), got[0], got[1], got[2]); end
    idle_all();
  endtask

  task automatic test_last_drop();
    drv(1'b0, 1'b1, 1'b1, 8'h44);
    step();
    #1;
    n_cmp++; if (ds() !== 16'hA044) begin n_bad++; $display("FAIL drop_first: got %h want %h", ds(), 16'hA044); end
    step();
    drv(1'b0, 1'b0, 1'b1, 8'h55);
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0) begin n_bad++; $display("FAIL drop_last_valid: got %b want %b", st(), 7'b1_01_1_01_0); end
    step();
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0) begin n_bad++; $display("FAIL drop_idle: got %b want %b", st(), 7'b0); end
    n_cmp++; if (got.size() != 2 || got[0] !== 16'hA044 || got[1] !== 16'hA055) begin n_bad++; $display("FAIL drop_bytes: got n=%0d %h %h want n=2 a044 a055", got.size(), got[0], got[1]); end
    idle_all();
  endtask

  task automatic test_two_req();
    pulse_reset();
    drv(1'b0, 1'b1, 1'b1, 8'h01);
    drv(1'b1, 1'b1, 1'b1, 8'h81);
    step();
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0 || ds() !== 16'hA001) begin n_bad++; $display("FAIL two_first: got %b/%h want %b/%h", st(), ds(), 7'b1_01_1_01_0, 16'hA001); end
    step();
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0) begin n_bad++; $display("FAIL two_gap: got %b want %b", st(), 7'b0); end
    step();
    #1;
    n_cmp++; if (st() !== 7'b1_10_1_10_0 || ds() !== 16'hB181) begin n_bad++; $display("FAIL two_second: got %b/%h want %b/%h", st(), ds(), 7'b1_10_1_10_0, 16'hB181); end
    drv(1'b1, 1'b0, 1'b1, 8'h81);
    step();
    n_cmp++; if (got.size() != 2 || got[0] !== 16'hA001 || got[1] !== 16'hB181) begin n_bad++; $display("FAIL two_bytes: got n=%0d %h %h want n=2 a001 b181", got.size(), got[0], got[1]); end
    idle_all();
  endtask

  task automatic test_hold();
    drv(1'b0, 1'b1, 1'b1, 8'h61);
    step();
    drv(1'b1, 1'b1, 1'b1, 8'h99);
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0) begin n_bad++; $display("FAIL hold_c1: got %b want %b", st(), 7'b1_01_1_01_0); end
    step();
    drv(1'b0, 1'b1, 1'b1, 8'h62);
    bus.upload_ready = 1'b0;
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_00_0) begin n_bad++; $display("FAIL hold_c2: got %b want %b", st(), 7'b1_01_1_00_0); end
    step();
    bus.upload_ready = 1'b1;
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0 || ds() !== 16'hA062) begin n_bad++; $display("FAIL hold_c3: got %b/%h want %b/%h", st(), ds(), 7'b1_01_1_01_0, 16'hA062); end
    step();
    drv(1'b0, 1'b1, 1'b1, 8'h63);
    step();
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0) begin n_bad++; $display("FAIL hold_gap: got %b want %b", st(), 7'b0); end
    step();
    #1;
    n_cmp++; if (st() !== 7'b1_10_1_10_0) begin n_bad++; $display("FAIL hold_next: got %b want %b", st(), 7'b1_10_1_10_0); end
    drv(1'b1, 1'b0, 1'b1, 8'h99);
    step();
    n_cmp++; if (got.size() != 4 || got[0] !== 16'hA061 || got[1] !== 16'hA062 || got[2] !== 16'hA063 || got[3] !== 16'hB199) begin n_bad++; $display("FAIL hold_bytes: got n=%0d %h %h %h %h want n=4 a061 a062 a063 b199", got.size(), got[0], got[1], got[2], got[3]); end
    idle_all();
  endtask

  task automatic test_reset_mid();
    drv(1'b0, 1'b1, 1'b1, 8'hA1);
    step();
    step();
    drv(1'b0, 1'b1, 1'b1, 8'hA2);
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0) begin n_bad++; $display("FAIL rmid_pre: got %b want %b", st(), 7'b1_01_1_01_0); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0 || ds() !== 16'h0000) begin n_bad++; $display("FAIL rmid_async: got %b/%h want %b/%h", st(), ds(), 7'b0, 16'h0); end
    step();
    rst_n = 1'b1;
    drv(1'b0, 1'b1, 1'b1, 8'hC1);
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0) begin n_bad++; $display("FAIL rmid_idle: got %b want %b", st(), 7'b0); end
    step();
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0 || ds() !== 16'hA0C1) begin n_bad++; $display("FAIL rmid_restart: got %b/%h want %b/%h", st(), ds(), 7'b1_01_1_01_0, 16'hA0C1); end
    drv(1'b0, 1'b0, 1'b1, 8'hC1);
    step();
    n_cmp++; if (got.size() != 2 || got[0] !== 16'hA0A1 || got[1] !== 16'hA0C1) begin n_bad++; $display("FAIL rmid_bytes: got n=%0d %h %h want n=2 a0a1 a0c1", got.size(), got[0], got[1]); end
    idle_all();
  endtask

`ifdef UPLOAD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    drv(1'b0, 1'b1, 1'b0, 8'h00);
    drv(1'b1, 1'b1, 1'b1, 8'h77);
    step();
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++; if (st() !== 7'b1_01_0_01_0) begin n_bad++; $display("FAIL to_wait%0d: got %b want %b", i, st(), 7'b1_01_0_01_0); end
      step();
    end
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_1) begin n_bad++; $display("FAIL to_pulse: got %b want %b", st(), 7'b0_00_0_00_1); end
    step();
    #1;
    n_cmp++; if (st() !== 7'b1_10_1_10_0 || ds() !== 16'hB177) begin n_bad++; $display("FAIL to_src1: got %b/%h want %b/%h", st(), ds(), 7'b1_10_1_10_0, 16'hB177); end
    drv(1'b1, 1'b0, 1'b1, 8'h77);
    step();
    step();
    step();
    #1;
    n_cmp++; if (st() !== 7'b0_00_0_00_0) begin n_bad++; $display("FAIL to_masked: got %b want %b", st(), 7'b0); end
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    drv(1'b0, 1'b1, 1'b1, 8'h5A);
    step();
    #1;
    n_cmp++; if (st() !== 7'b1_01_1_01_0) begin n_bad++; $display("FAIL to_regrant: got %b want %b", st(), 7'b1_01_1_01_0); end
    drv(1'b0, 1'b0, 1'b1, 8'h5A);
    step();
    n_cmp++; if (got.size() != 2 || got[0] !== 16'hB177 || got[1] !== 16'hA05A) begin n_bad++; $display("FAIL to_bytes: got n=%0d %h %h want n=2 b177 a05a", got.size(), got[0], got[1]); end
    idle_all();
  endtask
`else
  task automatic test_no_timeout();
    pulse_reset();
    drv(1'b0, 1'b1, 1'b0, 8'h00);
    drv(1'b1, 1'b1, 1'b1, 8'h77);
    step();
    repeat (40) step();
    #1;
    n_cmp++; if (st() !== 7'b1_01_0_01_0) begin n_bad++; $display("FAIL no_to_hold: got %b want %b", st(), 7'b1_01_0_01_0); end
    n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL no_to_bytes: got n=%0d want n=0", got.size()); end
    idle_all();
  endtask
`endif

  initial begin
    bus.src_upload_req = '0;
    bus.src_upload_valid = '0;
    bus.src_upload_data = '0;
    bus.src_upload_source = {8'hB1, 8'hA0};
    bus.upload_ready = 1'b0;
    test_reset();
    test_single();
    test_last_drop();
    test_two_req();
    test_hold();
    test_reset_mid();
`ifdef UPLOAD_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
